ap_txn_recorder: RTL
====================

# ap_txn_recorder

Synthesizable transaction recorder placed directly downstream of the per-module block-level handshake taps (ap_start/ap_ready/ap_done/ap_continue) of the MPSQ top and its sub-functions. For each monitored module it timestamps every start, measures start-to-done latency, and queues one record per completed transaction. Records go to a ready/valid output consumed by the status dump path. On `finish` it drains remaining records and then raises `drained`.

## Interface
- `NUM_MOD`, 3: number of monitored modules (1..8).
- `CNT_W`, 32: width of the cycle counter, start stamp and latency.
- `FIFO_DEPTH`, 16: output record FIFO depth (power of 2, ≥2).
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `finish`  in  1  end-of-run indication, level; sticky internally once seen.
- `ap_start`  in  NUM_MOD  per-module start tap.
- `ap_ready`  in  NUM_MOD  per-module ready tap (counted only).
- `ap_done`  in  NUM_MOD  per-module done tap.
- `ap_continue`  in  NUM_MOD  per-module continue; tie 1 for non-dataflow modules.
- `rec_valid`  out  1  record available.
- `rec_ready`  in  1  consumer accepts record.
- `rec_id`  out  3  module index.
- `rec_start`  out  CNT_W  cycle stamp of the transaction start.
- `rec_latency`  out  CNT_W  done stamp minus start stamp.
- `rec_trunc`  out  1  record closed by `finish`, not by `ap_done`.
- `drop_cnt`  out  16  saturating count of records lost to a full pending slot.
- `drained`  out  1  finish seen, no module RUN, all pending slots and FIFO empty.

## Operation
- Cycle counter `now`: 0 in the first cycle after reset release, +1 per cycle, saturates at all-ones, frozen once `finish` is seen.
- Per-module FSM (IDLE, RUN, HOLD):
  - IDLE: `ap_start` → capture `now` as start, go RUN. If `ap_start` and `ap_done` are both high, emit record with latency 0 and stay IDLE.
  - RUN: `ap_done & ap_continue` → emit record (latency = now − start), go IDLE. `ap_done & !ap_continue` → emit record, go HOLD.
  - HOLD: wait for `ap_continue`, then IDLE. `ap_done` seen in HOLD emits nothing.
  - `finish` while in RUN → emit with `rec_trunc=1`, go IDLE. All FSMs ignore inputs after `finish`.
- "Emit" loads that module's 1-entry pending slot. If the slot is occupied and not being drained that cycle, the new record is discarded and `drop_cnt` increments (saturating at 0xFFFF).
- Arbiter: each cycle, at most one pending slot is moved into the FIFO, round-robin starting after the last granted id, only when FIFO not full. A slot written and granted in the same cycle is legal.
- FIFO: first-word-fall-through. Pop on `rec_valid & rec_ready`. Full FIFO back-pressures the slots, never drops.
- `ap_ready` is sampled for a per-module ready counter (internal, debug only).

## Timing
- Reset values: `rec_valid=0`, `rec_id/rec_start/rec_latency/rec_trunc=0`, `drop_cnt=0`, `drained=0`, all FSMs IDLE, slots empty, FIFO empty, `now=0`.
- `ap_done` sampled at edge k → slot full after k → FIFO write at edge k+1 (if granted) → `rec_valid` high in the cycle after edge k+1. Minimum done-to-valid latency is 2 cycles.
- `rec_*` are stable while `rec_valid & !rec_ready`.
- Simultaneous push and pop on a full FIFO is allowed. Pop on empty is ignored.
- `drained` is registered and rises 1 cycle after its condition holds. It stays high until reset.
- Reset mid-transaction: all state is cleared immediately. No record is produced for the interrupted transaction.

## Structure
- Package `ap_mon_pkg`: `mod_state_e` (IDLE/RUN/HOLD), `txn_rec_t` struct {id, start, latency, trunc}, `ID_W=3`.
- Sub-module `rec_fifo`: parameterised FWFT sync FIFO of `txn_rec_t` with full/empty flags. Everything else lives in the top.

## Test plan
- Module 0 start at now=5, done&continue at now=17 → one record: id 0, start 5, latency 12, trunc 0, valid at now=19.
- Module 1: start and done in the same cycle at now=3 → record with latency 0. FSM remains IDLE; a start at now=4 opens a new transaction.
- Modules 0, 1, 2 done in the same cycle, rec_ready=1 → three records on consecutive cycles in round-robin order, no drops.
- rec_ready=0, FIFO_DEPTH=2, 4 completions on module 2 → FIFO holds 2, slot holds 1, 1 dropped (`drop_cnt=1`). Raising rec_ready then delivers 3 records in order.
- Module 0 done with ap_continue=0 → record emitted, state HOLD. A second done → no record. ap_continue=1 → IDLE.
- Module 2 in RUN when `finish` rises → trunc record, then `drained=1` after the consumer pops it. Reset asserted mid-RUN → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/ap_mon_pkg.sv
// ap_mon_pkg: shared types and helpers for the transaction recorder
package ap_mon_pkg;
  localparam int ID_W = 3;
  localparam int STAMP_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} mod_state_e;
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [STAMP_W-1:0] start;
    logic [STAMP_W-1:0] latency;
    logic               trunc;
  } txn_rec_t;
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'b0, b};
    return s[16] ? 16'hffff : s[15:0];
  endfunction
endpackage

// File: rtl/ap_txn_recorder_if.sv
// ap_txn_recorder_if: block-level handshake taps plus the record stream
interface ap_txn_recorder_if #(
  parameter int NUM_MOD = 3,
  parameter int CNT_W = 32
);
  logic [NUM_MOD-1:0]          ap_start;
  logic [NUM_MOD-1:0]          ap_ready;
  logic [NUM_MOD-1:0]          ap_done;
  logic [NUM_MOD-1:0]          ap_continue;
  logic                        rec_valid;
  logic                        rec_ready;
  logic [ap_mon_pkg::ID_W-1:0] rec_id;
  logic [CNT_W-1:0]            rec_start;
  logic [CNT_W-1:0]            rec_latency;
  logic                        rec_trunc;
  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, rec_ready,
    input  rec_valid, rec_id, rec_start, rec_latency, rec_trunc
  );
  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, rec_ready,
    output rec_valid, rec_id, rec_start, rec_latency, rec_trunc
  );
endinterface

// File: rtl/rec_fifo.sv
// rec_fifo: first-word-fall-through record FIFO; head reads zero while empty
module rec_fifo
  import ap_mon_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     push,
  input  txn_rec_t din,
  input  logic     pop,
  output txn_rec_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  txn_rec_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ap_txn_recorder.sv
// ap_txn_recorder: per-module start/done timing, one-entry pending slots,
// round-robin merge into a FWFT record FIFO, drain tracking after finish.
module ap_txn_recorder
  import ap_mon_pkg::*;
#(
  parameter int NUM_MOD = 3,
  parameter int CNT_W = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 finish,
  ap_txn_recorder_if.slave     bus,
  output logic [15:0]          drop_cnt,
  output logic                 drained
);
  logic fin_q, fin;
  logic [CNT_W-1:0] now;
  mod_state_e st_q [NUM_MOD];
  mod_state_e st_d [NUM_MOD];
  logic [CNT_W-1:0] start_q [NUM_MOD];
  logic [CNT_W-1:0] start_d [NUM_MOD];
  logic [15:0] rdy_cnt [NUM_MOD];
  txn_rec_t rec_new [NUM_MOD];
  txn_rec_t slot [NUM_MOD];
  logic [NUM_MOD-1:0] emit, slot_v, gnt, drop;
  logic [ID_W-1:0] last, gnt_id;
  logic gnt_any, can_push, any_run, fifo_full, fifo_empty;
  txn_rec_t fifo_din, head;
  assign fin = finish | fin_q;
  assign can_push = ~fifo_full | (~fifo_empty & bus.rec_ready);
  // A start+done in IDLE closes immediately with a zero-latency record.
  always_comb begin
    any_run = 1'b0;
    for (int i = 0; i < NUM_MOD; i++) begin
      st_d[i] = st_q[i];
      start_d[i] = start_q[i];
      emit[i] = 1'b0;
      any_run = any_run | (st_q[i] == RUN);
      rec_new[i].id = ID_W'(i);
      rec_new[i].start = STAMP_W'(st_q[i] == IDLE ? now : start_q[i]);
      rec_new[i].latency = st_q[i] == IDLE ? '0 : STAMP_W'(now - start_q[i]);
      rec_new[i].trunc = fin;
      if (fin) begin
        if (st_q[i] == RUN) begin
          emit[i] = 1'b1;
          st_d[i] = IDLE;
        end
      end else begin
        unique case (st_q[i])
          IDLE: if (bus.ap_start[i]) begin
            emit[i] = bus.ap_done[i];
            st_d[i] = bus.ap_done[i] ? IDLE : RUN;
            start_d[i] = now;
          end
          RUN: if (bus.ap_done[i]) begin
            emit[i] = 1'b1;
            st_d[i] = bus.ap_continue[i] ? IDLE : HOLD;
          end
          HOLD: st_d[i] = bus.ap_continue[i] ? IDLE : HOLD;
          default: st_d[i] = IDLE;
        endcase
      end
    end
  end
  // Search order begins one past the last granted id.
  always_comb begin
    gnt = '0;
    gnt_any = 1'b0;
    gnt_id = last;
    fifo_din = '0;
    for (int k = 1; k <= NUM_MOD; k++) begin
      for (int i = 0; i < NUM_MOD; i++) begin
        if (!gnt_any && can_push && slot_v[i] && i == (int'(last) + k) % NUM_MOD) begin
          gnt_any = 1'b1;
          gnt[i] = 1'b1;
          gnt_id = ID_W'(i);
          fifo_din = slot[i];
        end
      end
    end
    drop = emit & slot_v & ~gnt;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fin_q <= 1'b0;
      now <= '0;
      last <= ID_W'(NUM_MOD - 1);
      drop_cnt <= '0;
      drained <= 1'b0;
      slot_v <= '0;
      for (int i = 0; i < NUM_MOD; i++) begin
        st_q[i] <= IDLE;
        start_q[i] <= '0;
        slot[i] <= '0;
        rdy_cnt[i] <= '0;
      end
    end else begin
      fin_q <= fin;
      now <= (fin || &now) ? now : now + 1'b1;
      if (gnt_any) last <= gnt_id;
      drop_cnt <= sat_add16(drop_cnt, 4'($countones(drop)));
      drained <= drained | (fin_q & ~any_run & ~|slot_v & fifo_empty);
      for (int i = 0; i < NUM_MOD; i++) begin
        st_q[i] <= st_d[i];
        start_q[i] <= start_d[i];
        slot_v[i] <= emit[i] | (slot_v[i] & ~gnt[i]);
        if (emit[i] && (!slot_v[i] || gnt[i])) slot[i] <= rec_new[i];
        if (bus.ap_ready[i] && !fin && !(&rdy_cnt[i])) rdy_cnt[i] <= rdy_cnt[i] + 16'd1;
      end
    end
  end
  rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(gnt_any),
    .din(fifo_din),
    .pop(bus.rec_ready),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign bus.rec_valid = ~fifo_empty;
  assign bus.rec_id = head.id;
  assign bus.rec_start = CNT_W'(head.start);
  assign bus.rec_latency = CNT_W'(head.latency);
  assign bus.rec_trunc = head.trunc;
endmodule
